pixel_fetch: RTL
================

# pixel_fetch

Arbiter client that streams one frame of pixel bytes out of shared memory. On `frame_start` it walks a contiguous address range, issuing one read at a time on a single arbiter channel via req/addr/rdy, and buffers returned bytes in a small FIFO. A valid/ready byte stream feeds the downstream LED serializer.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 8: width of memory address.
- `DATA_WIDTH`, 8: width of memory word / output byte.
- `BASE_ADDR`, 0: first address of the frame.
- `NUM_WORDS`, 192: words per frame; 1..2^ADDRESS_WIDTH − BASE_ADDR.
- `FIFO_DEPTH`, 4: output buffer depth; power of two, ≥2.

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous active-high reset.
- `frame_start`  in  1: one-cycle pulse; begins a frame when idle.
- `busy`  out  1: high while a frame is being fetched.
- `frame_done`  out  1: one-cycle pulse when the last word of a frame is captured.
- `data_req`  out  1: arbiter channel request.
- `data_addr`  out  ADDRESS_WIDTH: arbiter channel address.
- `data_in`  in  DATA_WIDTH: arbiter channel data.
- `data_rdy`  in  1: arbiter channel ready.
- `out_data`  out  DATA_WIDTH: FIFO head.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: downstream accepts head this cycle.

## Operation
- State machine:
  - IDLE → REQ on `frame_start`. Load `addr = BASE_ADDR` and `remaining = NUM_WORDS`.
  - REQ: `data_req = 1` and `data_addr = addr`, held stable. REQ is entered only when FIFO count < FIFO_DEPTH. On `data_rdy = 1`, push `data_in` into the FIFO, increment `addr`, decrement `remaining`, and go to RELEASE.
  - RELEASE: `data_req = 0` for at least one cycle so the arbiter clears `data_rdy`. Exit conditions:
    - `remaining == 0` → IDLE.
    - `remaining != 0`, FIFO count < FIFO_DEPTH, and `data_rdy == 0` → REQ.
    - Otherwise stay in RELEASE.
- Only one request is outstanding, so a push in REQ always has space.
- FIFO: push and pop in the same cycle leaves the count unchanged. A pop occurs only when `out_valid & out_ready`. `out_data` is undefined when empty; the bench masks it.
- `busy = (state != IDLE)`.
- `frame_done` pulses in the cycle after the final push, i.e. the first RELEASE cycle with `remaining == 0`.
- `frame_start` while busy is ignored. The FIFO is not flushed between frames.
- `data_addr` is 0 when not in REQ.
- Address arithmetic is modulo 2^ADDRESS_WIDTH. The parameter range keeps a frame from wrapping.
- Reset mid-frame: the state goes to IDLE and `data_req` drops in the next cycle. FIFO is emptied and counters are cleared. No `frame_done` pulse is generated.

## Timing
- Reset values: `busy` 0, `frame_done` 0, `data_req` 0, `data_addr` 0, `out_valid` 0, `out_data` 0.
- `frame_start` sampled at edge N → `data_req` high after edge N.
- Arbiter latency is uncontested 2 edges from req high to rdy high. Push occurs on the edge where `data_rdy` is sampled high.
- Per-word cycle uncontested is 4 clocks: 2 in REQ, 1 RELEASE with rdy still high, 1 RELEASE with rdy low. The next REQ starts on the following edge.
- Push to `out_valid`: the word is visible the cycle after the push edge.
- Full FIFO with `out_ready` low: the block waits in RELEASE with `data_req` low indefinitely.

## Configuration
- Macro `PIXEL_FETCH_CONTINUOUS_EN`:
  - Defined: on leaving RELEASE with `remaining == 0`, reload `BASE_ADDR`/`NUM_WORDS` and continue to REQ under the normal space and rdy conditions. `busy` stays high. `frame_done` still pulses once per frame. `frame_start` is needed only from IDLE after reset.
  - Undefined: return to IDLE after each frame.

## Test plan
- Reset, then idle 10 cycles with `frame_start` low → `data_req` 0, `busy` 0, `out_valid` 0 throughout.
- Setup: NUM_WORDS=4, BASE_ADDR=0x10, memory model mem[a]=a^0xA5, `out_ready` held 1, uncontested arbiter. Pulse `frame_start` → addresses 0x10..0x13 requested in order. Output bytes are 0xB5, 0xB4, 0xB7, 0xB6. `frame_done` pulses once. `busy` falls 1 cycle later. 16 cycles per 4 words.
- Setup: FIFO_DEPTH=4, NUM_WORDS=8, `out_ready` 0 → exactly 4 requests, then `data_req` low indefinitely. Raising `out_ready` resumes the fetch, and all 8 bytes arrive in order.
- Competing higher-priority channel holds the arbiter for 20 cycles → `data_addr` stays stable while `data_req` is high. No push occurs before `data_rdy`.
- Assert `rst` while in REQ on word 2 → `data_req` 0 and FIFO empty on the next cycle. A subsequent `frame_start` restarts at BASE_ADDR.
- With `PIXEL_FETCH_CONTINUOUS_EN` and NUM_WORDS=3 → address sequence 0,1,2,0,1,2. `frame_done` pulses twice over 6 words. `busy` never drops.

Source files
------------

// File: rtl/pixel_fetch.sv
// Streams one frame of pixel bytes from shared memory through a single-request arbiter channel into a small output FIFO.
// Optional macro PIXEL_FETCH_CONTINUOUS_EN: restart the frame automatically instead of returning to idle.
module pixel_fetch #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int BASE_ADDR     = 0,
    parameter int NUM_WORDS     = 192,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     data_req,
    output logic [ADDRESS_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_rdy,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);
    // remaining needs one extra bit so a full 2^ADDRESS_WIDTH frame is representable
    localparam int REM_W = ADDRESS_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDRESS_WIDTH-1:0] BASE_A  = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [REM_W-1:0]         NUM_R   = REM_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0]         DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [REM_W-1:0]          remaining_q, remaining_d;
    logic                      done_q, done_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DATA_WIDTH-1:0]     fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_d [FIFO_DEPTH];
    logic                      push_s, pop_s, has_space_s;

    assign has_space_s = (count_q < DEPTH_C);
    assign push_s      = (state_q == S_REQ) && data_rdy;
    assign pop_s       = (count_q != {CNT_W{1'b0}}) && out_ready;

    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign data_req   = (state_q == S_REQ);
    assign data_addr  = (state_q == S_REQ) ? addr_q : {ADDRESS_WIDTH{1'b0}};
    assign out_valid  = (count_q != {CNT_W{1'b0}});
    assign out_data   = fifo_q[rd_ptr_q];

    // Next-state logic: a fetch only starts when the FIFO can take the word it returns
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    addr_d      = BASE_A;
                    remaining_d = NUM_R;
                    state_d     = has_space_s ? S_REQ : S_RELEASE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (data_rdy) begin
                    addr_d      = addr_q + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
                    remaining_d = remaining_q - {{(REM_W-1){1'b0}}, 1'b1};
                    done_d      = (remaining_q == {{(REM_W-1){1'b0}}, 1'b1});
                    state_d     = S_RELEASE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RELEASE: begin
                if (remaining_q == {REM_W{1'b0}}) begin
`ifdef PIXEL_FETCH_CONTINUOUS_EN
                    addr_d      = BASE_A;
                    remaining_d = NUM_R;
                    if (has_space_s && !data_rdy) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_RELEASE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else if (has_space_s && !data_rdy) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer, occupancy and storage update
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = data_in;
            wr_ptr_d         = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // State, counters and FIFO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= {ADDRESS_WIDTH{1'b0}};
            remaining_q <= {REM_W{1'b0}};
            done_q      <= 1'b0;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_q      <= fifo_d;
        end
    end
endmodule
